// File: rtl/shk_wr_sequencer.sv
// Command FIFO plus addr/data phase sequencer driving the shake write master bus.
// Each command: valid rise (addr byte), msync rise (data byte), then an idle gap.
module shk_wr_sequencer #(
   parameter int WD_SHK_DATA = 8,
   parameter int WD_SHK_ADDR = 8,
   parameter int WD_ERR_INFO = 4,
   parameter int DP_CMD_FIFO = 16,
   parameter int NB_TIMEOUT  = 20000,
   parameter int NB_GAP_CLKS = 4
)(
   input  logic                          i_sys_clk,
   input  logic                          i_sys_rst,
   input  logic                          i_cmd_valid,
   input  logic [WD_SHK_ADDR-1:0]        i_cmd_addr,
   input  logic [WD_SHK_DATA-1:0]        i_cmd_data,
   output logic                          o_cmd_ready,
   output logic [$clog2(DP_CMD_FIFO):0]  o_fifo_level,
   output logic                          o_busy,
   output logic                          m_shk_wr_valid,
   output logic                          m_shk_wr_msync,
   output logic [WD_SHK_ADDR-1:0]        m_shk_wr_maddr,
   output logic [WD_SHK_DATA-1:0]        m_shk_wr_mdata,
   input  logic                          m_shk_wr_ready,
   input  logic                          i_err_clr,
   output logic [WD_ERR_INFO-1:0]        m_err_seq_info
);
   localparam int PW = $clog2(DP_CMD_FIFO);
   localparam int LW = PW + 1;
   localparam int TW = $clog2(NB_TIMEOUT + 1);
   localparam int GW = $clog2(NB_GAP_CLKS + 1);
   localparam int CW = WD_SHK_ADDR + WD_SHK_DATA;
   localparam logic [TW-1:0] TMO_LAST = TW'(NB_TIMEOUT - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(NB_GAP_CLKS - 2);
   localparam logic [LW-1:0] LVL_FULL = LW'(DP_CMD_FIFO);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_GAP} state_t;
   state_t r_state, w_state_nxt;

   logic [CW-1:0]          r_mem [DP_CMD_FIFO];
   logic [PW-1:0]          r_wr_ptr, r_rd_ptr;
   logic [LW-1:0]          r_level;
   logic [TW-1:0]          r_timer;
   logic [GW-1:0]          r_gap_cnt;
   logic [3:0]             r_err, w_err_set;
   logic [WD_SHK_ADDR-1:0] r_maddr;
   logic [WD_SHK_DATA-1:0] r_mdata;
   logic                   w_full, w_push, w_pop, w_tmo, w_in_phase;

   assign w_full     = (r_level == LVL_FULL);
   assign w_push     = i_cmd_valid && !w_full;
   assign w_pop      = (r_state == S_IDLE) && (r_level != '0);
   assign w_tmo      = (r_timer == TMO_LAST);
   assign w_in_phase = (r_state == S_ADDR) || (r_state == S_DATA);

   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) r_state <= S_IDLE;
      else           r_state <= w_state_nxt;
   end

   // GAP lasts NB_GAP_CLKS-1 cycles; the IDLE pop cycle completes the NB_GAP_CLKS low window.
   always_comb begin
      w_state_nxt    = r_state;
      w_err_set      = '0;
      w_err_set[2]   = i_cmd_valid && w_full;
      m_shk_wr_valid = w_in_phase;
      m_shk_wr_msync = (r_state == S_DATA);
      o_busy         = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            w_err_set[3] = m_shk_wr_ready;
            if (w_pop) w_state_nxt = S_ADDR;
         end
         S_ADDR: begin
            if (m_shk_wr_ready) w_state_nxt = S_DATA;
            else if (w_tmo) begin
               w_err_set[0] = 1'b1;
               w_state_nxt  = S_GAP;
            end
         end
         S_DATA: begin
            if (m_shk_wr_ready) w_state_nxt = S_GAP;
            else if (w_tmo) begin
               w_err_set[1] = 1'b1;
               w_state_nxt  = S_GAP;
            end
         end
         S_GAP: begin
            w_err_set[3] = m_shk_wr_ready;
            if (r_gap_cnt == GAP_LAST) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_sys_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {i_cmd_addr, i_cmd_data};
   end

   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_level   <= '0;
         r_timer   <= '0;
         r_gap_cnt <= '0;
         r_err     <= '0;
         r_maddr   <= '0;
         r_mdata   <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) begin
            r_rd_ptr           <= r_rd_ptr + 1'b1;
            {r_maddr, r_mdata} <= r_mem[r_rd_ptr];
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
         r_timer   <= (w_in_phase && w_state_nxt == r_state) ? r_timer + 1'b1 : '0;
         r_gap_cnt <= (r_state == S_GAP && w_state_nxt == S_GAP) ? r_gap_cnt + 1'b1 : '0;
         r_err     <= i_err_clr ? w_err_set : (r_err | w_err_set);
      end
   end

   assign o_cmd_ready    = !w_full;
   assign o_fifo_level   = r_level;
   assign m_shk_wr_maddr = r_maddr;
   assign m_shk_wr_mdata = r_mdata;
   assign m_err_seq_info = WD_ERR_INFO'(r_err);
endmodule
